// File: rtl/ajuste_pkg.sv
// Shared definitions for the adjustment sequencer: FSM states, field and
// target encodings, and small decode helpers used by the top and the bench.
package ajuste_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    COMMIT = 3'd4
  } estado_t;

  localparam logic [1:0] CAMPO_NONE     = 2'b00;
  localparam logic [1:0] CAMPO_HORAS    = 2'b01;
  localparam logic [1:0] CAMPO_MINUTOS  = 2'b10;
  localparam logic [1:0] CAMPO_SEGUNDOS = 2'b11;

  localparam logic ALVO_RELOGIO = 1'b0;
  localparam logic ALVO_TIMER   = 1'b1;

  // Field selected while sitting in a given state.
  function automatic logic [1:0] campo_de(input estado_t s);
    case (s)
      EDIT_H:  campo_de = CAMPO_HORAS;
      EDIT_M:  campo_de = CAMPO_MINUTOS;
      EDIT_S:  campo_de = CAMPO_SEGUNDOS;
      default: campo_de = CAMPO_NONE;
    endcase
  endfunction

  // Field order on btn_next: H -> M -> S -> H.
  function automatic estado_t proximo_campo(input estado_t s);
    case (s)
      EDIT_H:  proximo_campo = EDIT_M;
      EDIT_M:  proximo_campo = EDIT_S;
      default: proximo_campo = EDIT_H;
    endcase
  endfunction

  function automatic logic em_edicao(input estado_t s);
    em_edicao = (s == EDIT_H) || (s == EDIT_M) || (s == EDIT_S);
  endfunction

endpackage

// File: rtl/ajuste_ctrl_btn_repeat.sv
// Rising-edge detector plus hold-to-repeat counter for one button.
// Ports:
//   clk, reset  - clock, async active-high reset
//   tick        - 1 kHz time-base enable
//   btn         - debounced button level (edge register always tracks it)
//   active      - button counts as held alone in an edit state this cycle;
//                 low clears the repeat counter
//   fire_c      - combinational strobe request (edge or repeat threshold)
module ajuste_ctrl_btn_repeat #(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  input  logic active,
  output logic fire_c
);

  logic             prev_q;
  logic             rep_q;   // first threshold passed, now using REPEAT_RATE
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  int unsigned      limit;
  logic             rise;
  logic             hit;

  // Saturating next count and threshold test.
  always_comb begin
    rise    = btn & ~prev_q;
    cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    limit   = rep_q ? REPEAT_RATE : REPEAT_DELAY;
    hit     = tick & (32'(cnt_nxt) >= limit);
    fire_c  = active & (rise | hit);
  end

  // Edge register and repeat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      rep_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= btn;
      if (!active) begin
        rep_q <= 1'b0;
        cnt_q <= '0;
      end else if (tick) begin
        if (hit) begin
          rep_q <= 1'b1;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/ajuste_ctrl.sv
// Clock/timer adjustment sequencer: field selection, inc/dec strobes with
// auto-repeat, blink of the selected field and a commit strobe on exit.
// Ports:
//   clk, reset           - clock, async active-high reset
//   tick_ms              - 1 kHz one-cycle enable
//   modo_ajuste_relogio  - clock-adjust mode (level, wins over timer)
//   modo_ajuste_timer    - timer-adjust mode (level)
//   btn_next/inc/dec     - debounced button levels
//   editing              - high in any edit state
//   target               - 0 clock, 1 timer; latched on entry
//   sel_campo            - 00 none, 01 hours, 10 minutes, 11 seconds
//   inc_pulse/dec_pulse  - one-cycle strobes for the selected field
//   blink                - 1 field visible, 0 blanked
//   commit               - one-cycle strobe when adjustment ends
module ajuste_ctrl #(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned BLINK_HALF   = 250,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_ms,
  input  logic       modo_ajuste_relogio,
  input  logic       modo_ajuste_timer,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       editing,
  output logic       target,
  output logic [1:0] sel_campo,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink,
  output logic       commit
);

  import ajuste_pkg::*;

  estado_t          state_q;
  logic             next_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] bcnt_nxt;
  logic             blink_hit;
  logic             adj;
  logic             alvo_req;
  logic             in_edit;
  logic             sair;
  logic             troca;
  logic             strobe_ok;
  logic             inc_active;
  logic             dec_active;
  logic             inc_fire;
  logic             dec_fire;

  // Decode of mode, exit, field change and per-button qualification.
  always_comb begin
    adj        = modo_ajuste_relogio | modo_ajuste_timer;
    alvo_req   = modo_ajuste_relogio ? ALVO_RELOGIO : ALVO_TIMER;
    in_edit    = em_edicao(state_q);
    // Leaving the mode, or flipping to the other target, ends the edit.
    sair       = in_edit & (~adj | (alvo_req != target));
    troca      = in_edit & ~sair & btn_next & ~next_q;
    strobe_ok  = in_edit & ~sair & ~troca;
    // Both buttons held: neither counts, both repeat counters stay at 0.
    inc_active = strobe_ok & btn_inc & ~btn_dec;
    dec_active = strobe_ok & btn_dec & ~btn_inc;
    bcnt_nxt   = (&bcnt_q) ? bcnt_q : bcnt_q + CNT_W'(1);
    blink_hit  = 32'(bcnt_nxt) >= BLINK_HALF;
  end

  ajuste_ctrl_btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_W        (CNT_W)
  ) u_rep_inc (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick_ms),
    .btn    (btn_inc),
    .active (inc_active),
    .fire_c (inc_fire)
  );

  ajuste_ctrl_btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_W        (CNT_W)
  ) u_rep_dec (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick_ms),
    .btn    (btn_dec),
    .active (dec_active),
    .fire_c (dec_fire)
  );

  // Sequencer FSM with registered outputs and blink timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      next_q    <= 1'b0;
      bcnt_q    <= '0;
      editing   <= 1'b0;
      target    <= ALVO_RELOGIO;
      sel_campo <= CAMPO_NONE;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      blink     <= 1'b1;
      commit    <= 1'b0;
    end else begin
      next_q    <= btn_next;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      commit    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (adj) begin
            state_q   <= EDIT_H;
            target    <= alvo_req;
            sel_campo <= CAMPO_HORAS;
            editing   <= 1'b1;
            blink     <= 1'b1;
            bcnt_q    <= '0;
          end
        end
        EDIT_H, EDIT_M, EDIT_S: begin
          if (sair) begin
            state_q   <= COMMIT;
            sel_campo <= CAMPO_NONE;
            editing   <= 1'b0;
            commit    <= 1'b1;
            blink     <= 1'b1;
            bcnt_q    <= '0;
          end else if (troca) begin
            state_q   <= proximo_campo(state_q);
            sel_campo <= campo_de(proximo_campo(state_q));
            blink     <= 1'b1;
            bcnt_q    <= '0;
          end else begin
            inc_pulse <= inc_fire;
            dec_pulse <= dec_fire;
            // A strobe makes the edited value visible and restarts the blink.
            if (inc_fire || dec_fire) begin
              blink  <= 1'b1;
              bcnt_q <= '0;
            end else if (tick_ms) begin
              if (blink_hit) begin
                blink  <= ~blink;
                bcnt_q <= '0;
              end else begin
                bcnt_q <= bcnt_nxt;
              end
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          sel_campo <= CAMPO_NONE;
          editing   <= 1'b0;
          blink     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ajuste_ctrl.sv
// Scoreboard bench for ajuste_ctrl: a behavioural model predicts the output
// vector for every cycle; a negedge monitor pops and compares.
module tb_ajuste_ctrl;

  localparam int unsigned D  = 5;
  localparam int unsigned R  = 2;
  localparam int unsigned BH = 3;

  typedef struct packed {
    logic       editing;
    logic       target;
    logic [1:0] sel;
    logic       inc;
    logic       dec;
    logic       blink;
    logic       commit;
  } exp_t;

  logic       clk, reset, tick;
  logic       rel, tim, nxt, inc, dec;
  logic       editing, target, inc_pulse, dec_pulse, blink, commit;
  logic [1:0] sel_campo;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t exp_q[$];

  ajuste_ctrl #(
    .REPEAT_DELAY (D),
    .REPEAT_RATE  (R),
    .BLINK_HALF   (BH),
    .CNT_W        (16)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .tick_ms             (tick),
    .modo_ajuste_relogio (rel),
    .modo_ajuste_timer   (tim),
    .btn_next            (nxt),
    .btn_inc             (inc),
    .btn_dec             (dec),
    .editing             (editing),
    .target              (target),
    .sel_campo           (sel_campo),
    .inc_pulse           (inc_pulse),
    .dec_pulse           (dec_pulse),
    .blink               (blink),
    .commit              (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: ph 0 idle, 1..3 editing field H/M/S, 4 committing.
  // Holds are counted in ticks; blink phase from ticks since last reload.
  int   ph, tgt, hi, hd, mb;
  logic pi, pd, pn;

  always @(posedge clk) begin
    exp_t e;
    logic adj, req, ri, rd, rn, fi, fd;
    if (reset) begin
      ph = 0; tgt = 0; hi = 0; hd = 0; mb = 0;
      pi = 1'b0; pd = 1'b0; pn = 1'b0;
      e = '{editing:1'b0, target:1'b0, sel:2'b00, inc:1'b0, dec:1'b0,
            blink:1'b1, commit:1'b0};
    end else begin
      adj = rel | tim;
      req = rel ? 1'b0 : 1'b1;
      ri = inc & ~pi; rd = dec & ~pd; rn = nxt & ~pn;
      fi = 1'b0; fd = 1'b0;
      if (ph == 0) begin
        hi = 0; hd = 0;
        if (adj) begin ph = 1; tgt = int'(req); mb = 0; end
      end else if (ph == 4) begin
        hi = 0; hd = 0; ph = 0;
      end else if (!adj || int'(req) != tgt) begin
        hi = 0; hd = 0; ph = 4;
      end else if (rn) begin
        hi = 0; hd = 0; mb = 0; ph = ph % 3 + 1;
      end else begin
        hi = (inc && !dec) ? hi + 1 : 0;
        hd = (dec && !inc) ? hd + 1 : 0;
        fi = (hi == 1 && ri) || (hi >= int'(D) && (hi - int'(D)) % int'(R) == 0);
        fd = (hd == 1 && rd) || (hd >= int'(D) && (hd - int'(D)) % int'(R) == 0);
        if (fi || fd) mb = 0; else mb = mb + 1;
      end
      pi = inc; pd = dec; pn = nxt;
      e.editing = (ph >= 1 && ph <= 3);
      e.target  = tgt[0];
      e.sel     = (ph >= 1 && ph <= 3) ? 2'(ph) : 2'b00;
      e.inc     = fi;
      e.dec     = fd;
      e.blink   = (ph >= 1 && ph <= 3) ? ((mb / int'(BH)) % 2 == 0) : 1'b1;
      e.commit  = (ph == 4);
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input exp_t act, input exp_t want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s @%0t: got ed=%0b tg=%0b sel=%b inc=%0b dec=%0b bl=%0b cm=%0b want ed=%0b tg=%0b sel=%b inc=%0b dec=%0b bl=%0b cm=%0b",
                  name, $time, act.editing, act.target, act.sel, act.inc, act.dec, act.blink, act.commit,
                  want.editing, want.target, want.sel, want.inc, want.dec, want.blink, want.commit);
  endtask

  // Monitor: compare DUT outputs away from the active edge.
  always @(negedge clk) begin
    exp_t act, want;
    act.editing = editing; act.target = target; act.sel = sel_campo;
    act.inc = inc_pulse; act.dec = dec_pulse; act.blink = blink; act.commit = commit;
    if (reset) begin
      exp_q.delete();
      want = '{editing:1'b0, target:1'b0, sel:2'b00, inc:1'b0, dec:1'b0,
               blink:1'b1, commit:1'b0};
      check("reset", act, want);
    end else if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard_empty @%0t: got no prediction, want one per cycle", $time);
    end else begin
      want = exp_q.pop_front();
      check("cycle", act, want);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_next();
    nxt = 1'b1; cyc(1); nxt = 1'b0; cyc(2);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1;
    rel = 1'b0; tim = 1'b0; nxt = 1'b0; inc = 1'b0; dec = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // Entry and exit through commit.
    rel = 1'b1; cyc(10); rel = 1'b0; cyc(4);

    // Field wrap H->M->S->H, then on to M.
    rel = 1'b1; cyc(3);
    repeat (3) pulse_next();
    pulse_next();

    // Auto-repeat on a held increment.
    inc = 1'b1; cyc(12); inc = 1'b0; cyc(3);

    // Both buttons, then drop decrement while increment stays held.
    inc = 1'b1; dec = 1'b1; cyc(10);
    dec = 1'b0; cyc(8);
    inc = 1'b0; cyc(2);

    // Priority with both flags, then flip to timer.
    tim = 1'b1; cyc(3);
    rel = 1'b0; cyc(6);

    // Go to seconds, let blink drop, reset mid-edit.
    nxt = 1'b1; cyc(1); nxt = 1'b0; cyc(1);
    nxt = 1'b1; cyc(1); nxt = 1'b0; cyc(3);
    reset = 1'b1; cyc(2); reset = 1'b0;
    tim = 1'b0; cyc(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rel = ~rel;
      if ($urandom_range(0, 59) == 0) tim = ~tim;
      if ($urandom_range(0, 9) == 0)  nxt = ~nxt;
      if ($urandom_range(0, 7) == 0)  inc = ~inc;
      if ($urandom_range(0, 9) == 0)  dec = ~dec;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; cyc(1); reset = 1'b0;
      end
      cyc(1);
    end

    rel = 1'b0; tim = 1'b0; nxt = 1'b0; inc = 1'b0; dec = 1'b0;
    cyc(5);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ajuste_ctrl.md
Name: ajuste_ctrl

Overview:
- Sequencer for the clock/timer adjustment datapath.
- Consumes the decoded mode flags modo_ajuste_relogio and modo_ajuste_timer and the user buttons.
- Selects which field (hours/minutes/seconds) is being edited and issues single-cycle increment/decrement strobes with hold-to-auto-repeat.
- Drives a blink enable for the selected display field and a commit strobe when adjustment ends.

Parameters:
- REPEAT_DELAY, 500, tick_ms periods a button is held before auto-repeat starts
- REPEAT_RATE, 100, tick_ms periods between auto-repeat strobes
- BLINK_HALF, 250, tick_ms periods per blink half-period
- CNT_W, 16, width of internal tick counters; must hold max(REPEAT_DELAY, REPEAT_RATE, BLINK_HALF)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick_ms  in  1  one-cycle enable, 1 kHz time base
- modo_ajuste_relogio  in  1  clock-adjust mode active (level)
- modo_ajuste_timer  in  1  timer-adjust mode active (level)
- btn_next  in  1  advance field, already synchronized/debounced (level)
- btn_inc  in  1  increment, synchronized/debounced (level)
- btn_dec  in  1  decrement, synchronized/debounced (level)
- editing  out  1  high in any EDIT state
- target  out  1  0 = clock registers, 1 = timer registers; latched on entry
- sel_campo  out  2  00 none, 01 hours, 10 minutes, 11 seconds
- inc_pulse  out  1  one-cycle increment strobe for selected field
- dec_pulse  out  1  one-cycle decrement strobe for selected field
- blink  out  1  1 = selected field visible, 0 = blanked
- commit  out  1  one-cycle strobe: adjustment finished, target registers final

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values: state IDLE; editing=0, target=0, sel_campo=00, inc_pulse=0, dec_pulse=0, commit=0, blink=1; all counters 0; button edge registers 0.
- All outputs are registered.
- Entry mode: adj = modo_ajuste_relogio | modo_ajuste_timer. If both flags are high, relogio has priority (target=0).
- FSM states: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- IDLE:
  - adj=1 -> EDIT_H next cycle; target latched; blink=1; blink counter cleared.
  - A button held at entry does not strobe; a fresh rising edge is required.
- EDIT_H/EDIT_M/EDIT_S:
  - btn_next rising edge advances H->M->S->H (wraps).
  - Field change reloads blink=1 and clears the blink counter and repeat counter.
- Any EDIT state with adj=0 -> COMMIT. This takes priority over btn_next and suppresses any inc/dec strobe that cycle.
- Mode flip between relogio and timer while editing (adj stays 1 but the requested target differs from the latched target) is treated as an exit: -> COMMIT.
- COMMIT:
  - commit=1 for exactly one cycle; sel_campo=00; editing=0; no strobes.
  - -> IDLE unconditionally; re-entry is possible the cycle after.
- sel_campo is 01/10/11 in EDIT_H/M/S and 00 otherwise; editing = (sel_campo != 00).
- Strobes, EDIT states only:
  - Rising edge of btn_inc alone -> inc_pulse the next cycle; btn_dec is symmetric.
  - btn_inc and btn_dec both high -> no strobes, repeat counter held at 0.
  - Release -> repeat counter cleared.
- Auto-repeat:
  - While a single button is held, the repeat counter counts tick_ms.
  - On reaching REPEAT_DELAY: one strobe, then one strobe every REPEAT_RATE ticks while still held.
  - A strobe is one clk cycle regardless of the tick_ms width.
- Blink:
  - In EDIT states, toggles every BLINK_HALF tick_ms.
  - Any inc/dec strobe forces blink=1 and clears the blink counter.
  - Outside EDIT states, blink=1.
- Counters saturate rather than wrap if tick parameters are misconfigured.
- Mid-operation reset: immediate IDLE and reset values; no commit is issued.

Decomposition:
- Shared package ajuste_pkg:
  - state enum (IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT)
  - field encodings CAMPO_NONE/HORAS/MINUTOS/SEGUNDOS
  - target encodings ALVO_RELOGIO/ALVO_TIMER
- One sub-module: btn_repeat, edge detect plus auto-repeat counter for one button, instantiated for inc and dec.
- Both-pressed masking and the FSM stay in ajuste_ctrl.

Test Plan:
- Bench parameters: REPEAT_DELAY=5, REPEAT_RATE=2, BLINK_HALF=3, tick_ms every cycle.
- Entry/exit:
  - Stimulus: modo_ajuste_relogio=1, hold 10 cycles, drop.
  - Required: next cycle editing=1, sel_campo=01, target=0; after the drop, one cycle with commit=1 and sel_campo=00, then IDLE.
- Field wrap:
  - Stimulus: in EDIT_H, pulse btn_next 3 times.
  - Required: sel_campo 01->10->11->01; blink=1 immediately after each change.
- Auto-repeat:
  - Stimulus: hold btn_inc 12 cycles in EDIT_M.
  - Required: inc_pulse at edge+1, again once the counter reaches 5, then every 2 ticks (5 strobes total); dec_pulse stays 0.
- Conflict:
  - Stimulus: btn_inc and btn_dec rising on the same cycle, held 10 cycles.
  - Required: no strobes.
  - Stimulus: release btn_dec.
  - Required: btn_inc alone gives no edge strobe; its first strobe comes once the counter reaches 5.
- Target flip and priority:
  - Stimulus: both mode flags high.
  - Required: target=0.
  - Stimulus: relogio drops while timer stays high.
  - Required: commit strobe, then IDLE, then EDIT_H with target=1.
- Reset mid-edit:
  - Stimulus: assert reset in EDIT_S with blink=0.
  - Required: immediately sel_campo=00, blink=1, commit never asserted.
